exec_stim_gen: RTL and testbench

Parametrised, synthesizable stimulus generator that stands in for the EXEC unit during IFD unit-level validation. It drives the stall and PC_value handshake into instr_decode with programmable inter-event spacing: fixed, LFSR-random or sweep. Runs a main phase of NUM_STEPS program-counter advances, then a jump to JUMP_PC to force the decoder's DONE path, then a short tail of extra steps. Usable in simulation and on an FPGA bench.

---
 rtl/exec_stim_gen.sv | 181 ++++++++++++++++++
 tb/tb_exec_stim_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stim_gen.sv
// Stand-in for the EXEC unit during IFD validation: drives the stall / PC_value
// handshake with fixed, LFSR-random or sweep spacing through main, jump and tail phases.
module exec_stim_gen #(
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] START_PC   = 12'o200,
   parameter logic [ADDR_WIDTH-1:0] JUMP_PC    = 12'h080,
   parameter int                    NUM_STEPS  = 1000,
   parameter int                    TAIL_STEPS = 5,
   parameter int                    MAX_DELAY  = 15,
   parameter int                    MIN_GAP    = 2,
   parameter int                    DW         = $clog2(MAX_DELAY + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic [1:0]            delay_mode,
   input  logic [DW-1:0]         fixed_delay,
   input  logic [15:0]           seed,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] PC_value,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           step_count
);
   // state     | meaning
   // IDLE      | after reset, waiting for start
   // WAIT_A    | stall edge issued, counting the gap before the PC advance
   // WAIT_B    | PC advanced, counting the gap before next stall edge / jump / done
   // JUMP_WAIT | PC_value = JUMP_PC with stall low, counting the gap
   // TAIL_GAP  | stall high for exactly one cycle before the tail phase
   // DONE      | run complete, outputs hold until the next start
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_A    = 3'd1,
      WAIT_B    = 3'd2,
      JUMP_WAIT = 3'd3,
      TAIL_GAP  = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam int             TW      = $clog2(MAX_DELAY + MIN_GAP + 1);
   localparam logic [DW-1:0]  D_MAX   = DW'(MAX_DELAY - 1);
   localparam logic [TW-1:0]  GAP_OFS = TW'(MIN_GAP - 1);
   localparam logic [31:0]    MAIN_N  = 32'(NUM_STEPS);
   localparam logic [31:0]    TOTAL_N = 32'(NUM_STEPS + TAIL_STEPS);

   state_t          state;
   logic            tail;
   logic [TW-1:0]   timer;
   logic [15:0]     lfsr;
   logic [DW-1:0]   sweep;

   logic [15:0]     seed_eff;
   logic [15:0]     lfsr_src;
   logic [15:0]     lfsr_adv;
   logic [15:0]     lfsr_draw;
   logic [DW-1:0]   sweep_draw;
   logic [DW-1:0]   d_cur;
   logic [TW-1:0]   gap_load;
   logic            idle_like;
   logic            expired;
   logic            more_steps;

   // A start draws from the freshly reloaded seed, so the draw source switches there.
   always_comb begin
      seed_eff   = (seed == 16'h0) ? 16'hACE1 : seed;
      idle_like  = (state == IDLE) || (state == DONE);
      lfsr_src   = idle_like ? seed_eff : lfsr;
      lfsr_adv   = (lfsr_src >> 1) ^ (lfsr_src[0] ? 16'hB400 : 16'h0000);
      expired    = (timer == '0);
      more_steps = tail ? (step_count != TOTAL_N) : (step_count != MAIN_N);
      lfsr_draw  = lfsr_src;
      sweep_draw = sweep;
      d_cur      = '0;
      case (delay_mode)
         2'd1: begin
            d_cur     = DW'(lfsr_src % 16'(MAX_DELAY));
            lfsr_draw = lfsr_adv;
         end
         2'd2: begin
            d_cur      = sweep;
            sweep_draw = (sweep == D_MAX) ? '0 : sweep + DW'(1);
         end
         default: d_cur = (fixed_delay > D_MAX) ? D_MAX : fixed_delay;
      endcase
      gap_load = TW'(d_cur) + GAP_OFS;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         stall      <= 1'b1;
         PC_value   <= START_PC;
         busy       <= 1'b0;
         done       <= 1'b0;
         step_count <= '0;
         tail       <= 1'b0;
         timer      <= '0;
         lfsr       <= seed_eff;
         sweep      <= '0;
      end else if (!pause) begin
         if (!expired) timer <= timer - TW'(1);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  step_count <= '0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  tail       <= 1'b0;
                  stall      <= 1'b0;
                  lfsr       <= lfsr_draw;
                  sweep      <= sweep_draw;
                  timer      <= gap_load;
                  if (NUM_STEPS == 0) begin
                     PC_value <= JUMP_PC;
                     state    <= JUMP_WAIT;
                  end else begin
                     PC_value <= START_PC;
                     state    <= WAIT_A;
                  end
               end
            end
            WAIT_A: begin
               if (expired) begin
                  PC_value   <= PC_value + ADDR_WIDTH'(1);
                  step_count <= step_count + 32'd1;
                  lfsr       <= lfsr_draw;
                  sweep      <= sweep_draw;
                  timer      <= gap_load;
                  state      <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (expired) begin
                  if (more_steps) begin
                     stall <= ~stall;
                     lfsr  <= lfsr_draw;
                     sweep <= sweep_draw;
                     timer <= gap_load;
                     state <= WAIT_A;
                  end else if (!tail) begin
                     stall    <= 1'b0;
                     PC_value <= JUMP_PC;
                     lfsr     <= lfsr_draw;
                     sweep    <= sweep_draw;
                     timer    <= gap_load;
                     state    <= JUMP_WAIT;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            JUMP_WAIT: begin
               if (expired) begin
                  stall <= 1'b1;
                  if (TAIL_STEPS == 0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= TAIL_GAP;
                  end
               end
            end
            TAIL_GAP: begin
               stall <= 1'b0;
               tail  <= 1'b1;
               lfsr  <= lfsr_draw;
               sweep <= sweep_draw;
               timer <= gap_load;
               state <= WAIT_A;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stim_gen.sv
// Bench for exec_stim_gen: three parameterisations checked cycle by cycle against
// an event-timeline model built from the run rules.
module tb_exec_stim_gen;
   localparam int P_NUM   [3] = '{2, 6, 0};
   localparam int P_TAIL  [3] = '{1, 0, 3};
   localparam int P_START [3] = '{'o200, 'o7777, 'o200};
   localparam int P_JUMP  [3] = '{'h080, 'h080, 'hFFE};
   localparam int P_MAXD  [3] = '{15, 4, 15};
   localparam int P_MING  [3] = '{2, 2, 1};
   localparam int P_FMASK [3] = '{15, 7, 15};

   logic        clk;
   logic        reset;
   logic        pause;
   logic        start_v [3];
   logic [1:0]  delay_mode;
   logic [3:0]  fixed_delay;
   logic [15:0] seed;
   logic        stall_v [3];
   logic [11:0] pc_v    [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [31:0] steps_v [3];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int t;
      bit st;
      int pc;
      int steps;
      bit dn;
   } ev_t;

   ev_t evq[$];
   int  m_sweep [3];

   exec_stim_gen #(.NUM_STEPS(2), .TAIL_STEPS(1)) u_d0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .pause(pause),
      .delay_mode(delay_mode), .fixed_delay(fixed_delay), .seed(seed),
      .stall(stall_v[0]), .PC_value(pc_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .step_count(steps_v[0]));

   exec_stim_gen #(.START_PC(12'o7777), .NUM_STEPS(6), .TAIL_STEPS(0), .MAX_DELAY(4)) u_d1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .pause(pause),
      .delay_mode(delay_mode), .fixed_delay(fixed_delay[2:0]), .seed(seed),
      .stall(stall_v[1]), .PC_value(pc_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .step_count(steps_v[1]));

   exec_stim_gen #(.JUMP_PC(12'hFFE), .NUM_STEPS(0), .TAIL_STEPS(3), .MIN_GAP(1)) u_d2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .pause(pause),
      .delay_mode(delay_mode), .fixed_delay(fixed_delay), .seed(seed),
      .stall(stall_v[2]), .PC_value(pc_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .step_count(steps_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time budget exceeded, got still running, want finished");
      $fatal(1, "watchdog expired");
   end

   // Gap length for one draw, advancing the per-run LFSR or the per-DUT sweep.
   function automatic int draw(input int id, input int mode, input int fixed, inout int lf);
      int md = P_MAXD[id];
      int d;
      if (mode == 1) begin
         d  = lf % md;
         lf = (lf >> 1) ^ (((lf & 1) != 0) ? 'hB400 : 0);
      end else if (mode == 2) begin
         d           = m_sweep[id];
         m_sweep[id] = (m_sweep[id] + 1) % md;
      end else begin
         d = (fixed > md - 1) ? md - 1 : fixed;
      end
      return d + P_MING[id];
   endfunction

   function automatic void push_ev(input int t, input bit st, input int pc, input int steps, input bit dn);
      ev_t e;
      e.t = t; e.st = st; e.pc = pc & 'hFFF; e.steps = steps; e.dn = dn;
      evq.push_back(e);
   endfunction

   // Timeline of output values (relative to the start edge) for one complete run.
   function automatic void build(input int id, input int mode, input int fixed, input int sd);
      int t = 0;
      int pc = P_START[id];
      int steps = 0;
      int g;
      int lf;
      bit st = 1'b0;
      evq.delete();
      lf = (sd == 0) ? 'hACE1 : sd;
      g  = draw(id, mode, fixed, lf);
      if (P_NUM[id] == 0) pc = P_JUMP[id];
      push_ev(0, st, pc, 0, 1'b0);
      for (int k = 1; k <= P_NUM[id]; k++) begin
         t += g; pc = (pc + 1) & 'hFFF; steps++;
         g = draw(id, mode, fixed, lf);
         push_ev(t, st, pc, steps, 1'b0);
         t += g;
         if (k < P_NUM[id]) st = !st;
         else begin st = 1'b0; pc = P_JUMP[id]; end
         g = draw(id, mode, fixed, lf);
         push_ev(t, st, pc, steps, 1'b0);
      end
      t += g; st = 1'b1;
      if (P_TAIL[id] == 0) begin
         push_ev(t, st, pc, steps, 1'b1);
      end else begin
         push_ev(t, st, pc, steps, 1'b0);
         t += 1; st = 1'b0;
         g = draw(id, mode, fixed, lf);
         push_ev(t, st, pc, steps, 1'b0);
         for (int k = 1; k <= P_TAIL[id]; k++) begin
            t += g; pc = (pc + 1) & 'hFFF; steps++;
            g = draw(id, mode, fixed, lf);
            push_ev(t, st, pc, steps, 1'b0);
            t += g;
            if (k < P_TAIL[id]) begin
               st = !st;
               g  = draw(id, mode, fixed, lf);
               push_ev(t, st, pc, steps, 1'b0);
            end else begin
               push_ev(t, st, pc, steps, 1'b1);
            end
         end
      end
   endfunction

   // Start a run on DUT id and compare every cycle against the timeline, with an
   // optional pause window (edges p_at+1..p_at+p_len) and a start pulse at edge s_at.
   task automatic run_check(input int id, input int mode, input int fixed, input int sd,
                            input int p_at, input int p_len, input int s_at, input string nm);
      int tend, eff, k;
      bit ok = 1'b1;
      logic [46:0] exp_v, act_v;
      build(id, mode, fixed & P_FMASK[id], sd & 'hFFFF);
      tend = evq[evq.size()-1].t + p_len + 3;
      @(negedge clk);
      delay_mode  = 2'(mode);
      fixed_delay = 4'(fixed);
      seed        = 16'(sd);
      pause       = 1'b0;
      start_v[id] = 1'b1;
      for (int c = 0; c <= tend; c++) begin
         @(negedge clk);
         if (c <= p_at) eff = c;
         else if (c <= p_at + p_len) eff = p_at;
         else eff = c - p_len;
         k = 0;
         for (int i = 0; i < evq.size(); i++) if (evq[i].t <= eff) k = i;
         exp_v = {evq[k].st, evq[k].dn, !evq[k].dn, 12'(evq[k].pc), 32'(evq[k].steps)};
         act_v = {stall_v[id], done_v[id], busy_v[id], pc_v[id], steps_v[id]};
         if (ok) begin
            n_cmp++;
            if (act_v !== exp_v) begin
               n_err++;
               ok = 1'b0;
               $display("FAIL %s cycle %0d: got stall=%b done=%b busy=%b pc=%o steps=%0d, want stall=%b done=%b busy=%b pc=%o steps=%0d",
                        nm, c, act_v[46], act_v[45], act_v[44], act_v[43:32], act_v[31:0],
                        exp_v[46], exp_v[45], exp_v[44], exp_v[43:32], exp_v[31:0]);
            end
         end
         start_v[id] = (c + 1 == s_at);
         pause       = (p_len > 0) && (c >= p_at) && (c < p_at + p_len);
      end
      start_v[id] = 1'b0;
      pause       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({stall_v[i], busy_v[i], done_v[i], pc_v[i], steps_v[i]} !== {1'b1, 1'b0, 1'b0, 12'(P_START[i]), 32'd0}) begin
            n_err++;
            $display("FAIL reset_d%0d: got stall=%b busy=%b done=%b pc=%o steps=%0d, want 1 0 0 %o 0",
                     i, stall_v[i], busy_v[i], done_v[i], pc_v[i], steps_v[i], P_START[i]);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) m_sweep[i] = 0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({stall_v[i], busy_v[i], pc_v[i]} !== {1'b1, 1'b0, 12'(P_START[i])}) begin
            n_err++;
            $display("FAIL idle_hold_d%0d: got stall=%b busy=%b pc=%o, want 1 0 %o",
                     i, stall_v[i], busy_v[i], pc_v[i], P_START[i]);
         end
      end
   endtask

   task automatic test_fixed();
      run_check(0, 0, 3, 0, 0, 0, 0, "d0_fixed3");
      run_check(0, 3, 5, 0, 0, 0, 0, "d0_mode3");
      run_check(0, 0, 0, 0, 0, 0, 0, "d0_fixed0");
      n_cmp++;
      if ({pc_v[0], steps_v[0], done_v[0], busy_v[0]} !== {12'h081, 32'd3, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL d0_end_state: got pc=%h steps=%0d done=%b busy=%b, want 081 3 1 0",
                  pc_v[0], steps_v[0], done_v[0], busy_v[0]);
      end
   endtask

   task automatic test_pause_done();
      pause = 1'b1; start_v[0] = 1'b1; delay_mode = 2'd0; fixed_delay = 4'd0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({done_v[0], busy_v[0], steps_v[0]} !== {1'b1, 1'b0, 32'd3}) begin
         n_err++;
         $display("FAIL pause_blocks_start: got done=%b busy=%b steps=%0d, want 1 0 3",
                  done_v[0], busy_v[0], steps_v[0]);
      end
      pause = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b0;
      n_cmp++;
      if ({done_v[0], busy_v[0], stall_v[0], pc_v[0], steps_v[0]} !== {1'b0, 1'b1, 1'b0, 12'o200, 32'd0}) begin
         n_err++;
         $display("FAIL restart_from_done: got done=%b busy=%b stall=%b pc=%o steps=%0d, want 0 1 0 200 0",
                  done_v[0], busy_v[0], stall_v[0], pc_v[0], steps_v[0]);
      end
      for (int i = 0; i < 200 && !done_v[0]; i++) @(negedge clk);
      n_cmp++;
      if ({done_v[0], steps_v[0]} !== {1'b1, 32'd3}) begin
         n_err++;
         $display("FAIL restart_completes: got done=%b steps=%0d, want 1 3 within 200 cycles",
                  done_v[0], steps_v[0]);
      end
   endtask

   task automatic test_pause();
      run_check(0, 0, 3, 0, 2, 7, 0, "d0_pause7_wait_a");
      run_check(1, 1, 0, 'h1234, 9, 4, 0, "d1_pause_random");
   endtask

   task automatic test_wrap();
      run_check(1, 0, 1, 0, 0, 0, 0, "d1_wrap");
      run_check(2, 0, 2, 0, 0, 0, 0, "d2_no_main_wrap");
   endtask

   task automatic test_clamp();
      run_check(0, 0, 15, 0, 0, 0, 0, "d0_clamp15");
      run_check(1, 0, 7, 0, 0, 0, 0, "d1_clamp7");
   endtask

   task automatic test_sweep();
      run_check(1, 2, 0, 0, 0, 0, 0, "d1_sweep_a");
      run_check(1, 2, 0, 0, 0, 0, 0, "d1_sweep_b");
      run_check(0, 2, 0, 0, 0, 0, 0, "d0_sweep");
      run_check(2, 2, 0, 0, 0, 0, 0, "d2_sweep");
   endtask

   task automatic test_random();
      run_check(0, 1, 0, 0, 0, 0, 0, "d0_seed0_a");
      run_check(0, 1, 0, 0, 0, 0, 0, "d0_seed0_b");
      run_check(0, 1, 0, 'hACE1, 0, 0, 0, "d0_seedace1");
      run_check(1, 1, 0, int'($urandom_range(1, 65535)), 0, 0, 0, "d1_random");
      run_check(2, 1, 0, int'($urandom_range(1, 65535)), 0, 0, 0, "d2_random");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 14; r++) begin
         int id, mode, fx, sd, pat, plen, sat;
         id   = int'($urandom_range(0, 2));
         mode = int'($urandom_range(0, 3));
         fx   = int'($urandom_range(0, 15));
         sd   = int'($urandom_range(0, 65535));
         pat  = int'($urandom_range(0, 20));
         plen = int'($urandom_range(0, 9));
         sat  = (r % 2 == 0) ? 2 : 0;
         run_check(id, mode, fx, sd, pat, plen, sat, $sformatf("rand%0d_d%0d_m%0d", r, id, mode));
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      delay_mode = 2'd0; fixed_delay = 4'd3; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (7) @(negedge clk);
      n_cmp++;
      if ({busy_v[0], stall_v[0], pc_v[0]} !== {1'b1, 1'b0, 12'o201}) begin
         n_err++;
         $display("FAIL mid_run_state: got busy=%b stall=%b pc=%o, want 1 0 201",
                  busy_v[0], stall_v[0], pc_v[0]);
      end
      reset = 1'b1; pause = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({stall_v[0], pc_v[0], done_v[0], busy_v[0], steps_v[0]} !== {1'b1, 12'o200, 1'b0, 1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_mid_run: got stall=%b pc=%o done=%b busy=%b steps=%0d, want 1 200 0 0 0",
                  stall_v[0], pc_v[0], done_v[0], busy_v[0], steps_v[0]);
      end
      reset = 1'b0; pause = 1'b0; start_v[0] = 1'b0;
      for (int i = 0; i < 3; i++) m_sweep[i] = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({stall_v[0], busy_v[0], pc_v[0]} !== {1'b1, 1'b0, 12'o200}) begin
         n_err++;
         $display("FAIL idle_after_reset: got stall=%b busy=%b pc=%o, want 1 0 200",
                  stall_v[0], busy_v[0], pc_v[0]);
      end
      run_check(1, 2, 0, 0, 0, 0, 0, "d1_sweep_after_reset");
   endtask

   initial begin
      reset = 1'b1; pause = 1'b0;
      for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; m_sweep[i] = 0; end
      delay_mode = 2'd0; fixed_delay = 4'd0; seed = 16'h0;
      test_reset();
      test_fixed();
      test_pause_done();
      test_pause();
      test_wrap();
      test_clamp();
      test_sweep();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
